cp0_timer_ctrl: RTL and testbench
=================================

# cp0_timer_ctrl

Parametrised coprocessor-0 for the P7 pipeline, in the M stage. It holds SR, Cause, EPC and PRId, plus BadVAddr, Count and Compare. It arbitrates interrupts against synchronous exceptions and raises a single-cycle `req` to flush the pipeline and redirect fetch. Compared with the previous CP0 it adds a configurable hardware-interrupt count, a built-in Count/Compare timer feeding one interrupt line, and BadVAddr capture for address exceptions.

## Interface
Parameters:
- `NUM_HWINT`, default 6: external interrupt lines, 1..6; line i maps to IM/IP bit 10+i.
- `TIMER_LINE`, default 5: interrupt line the timer is ORed into; must be < `NUM_HWINT`.
- `PRID_VAL`, default 32'h2001_1123: PRId constant.

Ports:
- Reset `reset`, synchronous, active-high; clock `clk`.
- `raddr`, in, 5: read register number for `mfc0`.
- `waddr`, in, 5: write register number for `mtc0`.
- `wdata`, in, 32: `mtc0` data.
- `we`, in, 1: `mtc0` write enable.
- `pc`, in, 32: PC of the M-stage instruction.
- `excode`, in, 5: exception code of the M-stage instruction; 0 means none.
- `bd_in`, in, 1: the M-stage instruction is in a delay slot.
- `badvaddr_in`, in, 32: faulting address; valid when `excode` is 4 or 5.
- `hwint`, in, `NUM_HWINT`: level-sensitive external interrupts.
- `eret`, in, 1: `eret` is in M; clears EXL.
- `req`, out, 1: take an exception or interrupt this cycle.
- `epc_out`, out, 32: exception PC when `req` is high, otherwise the EPC register.
- `rdata`, out, 32: selected CP0 register.
- `timer_irq`, out, 1: timer pending bit (Cause.TI).

## Operation
Register map:
- 8 BadVAddr, 9 Count, 11 Compare, 12 SR, 13 Cause, 14 EPC, 15 PRId.
- Any other address reads 0.

SR fields:
- IM = sr[10 +: NUM_HWINT], EXL = sr[1], IE = sr[0].
- Only these bits are writable; all other bits read 0.

Cause fields:
- BD = [31], TI = [30], IP = [10 +: NUM_HWINT], ExcCode = [6:2].
- Cause is read-only.

Interrupt and exception request:
- `line[i] = hwint[i] | (i == TIMER_LINE & TI)`.
- `req_int = |(line & IM) & IE & !EXL`.
- `req_ex = (excode != 0) & !EXL`.
- `req = req_int | req_ex`, combinational.

Effects of `req`, applied at the clock edge:
- EXL <= 1.
- BD <= `bd_in`.
- EPC <= (`bd_in` ? `pc` - 4 : `pc`).
- ExcCode <= 0 if `req_int`, else `excode`. Interrupt takes precedence over exception.
- BadVAddr <= `badvaddr_in` only when `!req_int` and `excode` is 4 or 5.
- All `mtc0` writes in that cycle are suppressed.

Other register behaviour:
- `eret`: EXL <= 0. If `req` fires in the same cycle, EXL ends at 1.
- IP <= `line`, every cycle.
- Count: +1 every cycle and wraps at 2^32. An `mtc0` to Count loads `wdata` with no increment that cycle.
- TI: set when Count == Compare (registered compare) and remains set. An `mtc0` to Compare clears TI and loads Compare; if a match occurs in the same cycle, the clear wins.
- BadVAddr, PRId: not writable.

Read path:
- `rdata` is combinational from `raddr`.
- EPC reads `epc_out`, so it shows the bypassed value during `req`.

## Timing
- Reset values: SR, Cause, EPC, BadVAddr, Count and Compare are 0; TI is 0; PRId is `PRID_VAL`.
- Outputs after reset: `req` = 0, `timer_irq` = 0, `epc_out` = 0.
- Register writes become visible to `rdata` on the cycle after the edge.
- `req` has zero-cycle latency from `hwint`, `excode` and SR.
- Timer: with Compare = N written at Count = c, TI rises on the edge where Count transitions N → N+1, i.e. N−c+1 cycles after the write. With c = 0 this is N+1 cycles.
- Reset mid-operation clears every register on the next edge, including a pending TI and an in-progress EXL.

## Structure
- The shared package `cp0_defs` holds the register-number constants (8, 9, 11–15), the ExcCode constants (Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12) and the SR/Cause bit-position constants.
- Sub-module `cp0_timer`: owns Count, Compare and TI, and takes `we`/`waddr`/`wdata`.

## Test plan
- Set SR = 0x0000_8401, then raise `hwint[5]` → `req` = 1 in the same cycle. Next cycle Cause[6:2] = 0 and EXL = 1. Raising `hwint[5]` again gives `req` = 0.
- Write `excode` = 4, `pc` = 0x3004, `bd_in` = 1, `badvaddr_in` = 0x1001 → `epc_out` = 0x3000. Next cycle Cause = 0x8000_0010 and BadVAddr = 0x1001.
- Write Compare = 10 right after reset with SR = 0x0000_8401 → `timer_irq` rises 11 cycles after the write and `req` follows. An `mtc0` to Compare clears `timer_irq`.
- `mtc0` to EPC (0x5000) in the same cycle as `excode` = 12 with `pc` = 0x3008 → the write is suppressed and EPC = 0x3008.
- `eret` and `req_ex` in the same cycle → EXL = 1. A lone `eret` → EXL = 0.
- Assert `reset` while EXL = 1 and TI = 1 → SR and Cause read 0 and Count restarts at 0.

Source files
------------

// File: rtl/cp0_defs.sv
// Shared CP0 definitions: register numbers, exception codes and field positions.
package cp0_defs;

   // CP0 register numbers
   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_SR       = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // SR field positions
   localparam int SR_IE     = 0;
   localparam int SR_EXL    = 1;
   localparam int SR_IM_LSB = 10;

   // Cause field positions
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_TI      = 30;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_EXC_LSB = 2;

   // Address-error exceptions are the only ones that capture BadVAddr.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare register and the sticky TI bit.
module cp0_timer
   import cp0_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_ti
);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_ti;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_match;

   // Write decodes; i_we is already gated off by the parent during an exception.
   assign w_wr_count   = i_we && (i_waddr == REG_COUNT);
   assign w_wr_compare = i_we && (i_waddr == REG_COMPARE);
   // Compare against the registered values, so TI rises on the N -> N+1 edge.
   assign w_match      = (r_count == r_compare);

   // Count increments every cycle unless loaded; Compare write clears TI, beating a same-cycle match.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_compare <= '0;
         r_ti      <= 1'b0;
      end else begin
         r_count <= w_wr_count ? i_wdata : (r_count + 32'd1);
         if (w_wr_compare) begin
            r_compare <= i_wdata;
         end
         if (w_wr_compare) begin
            r_ti <= 1'b0;
         end else if (w_match) begin
            r_ti <= 1'b1;
         end
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_timer_ctrl.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC/PRId/BadVAddr plus the Count/Compare
// timer, with interrupt-over-exception arbitration and a combinational flush request.
module cp0_timer_ctrl
   import cp0_defs::*;
#(
   parameter int          NUM_HWINT  = 6,
   parameter int          TIMER_LINE = 5,
   parameter logic [31:0] PRID_VAL   = 32'h2001_1123
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           raddr,
   input  logic [4:0]           waddr,
   input  logic [31:0]          wdata,
   input  logic                 we,
   input  logic [31:0]          pc,
   input  logic [4:0]           excode,
   input  logic                 bd_in,
   input  logic [31:0]          badvaddr_in,
   input  logic [NUM_HWINT-1:0] hwint,
   input  logic                 eret,
   output logic                 req,
   output logic [31:0]          epc_out,
   output logic [31:0]          rdata,
   output logic                 timer_irq
);

   // SR state
   logic [NUM_HWINT-1:0] r_im;
   logic                 r_exl;
   logic                 r_ie;
   // Cause state
   logic                 r_bd;
   logic [NUM_HWINT-1:0] r_ip;
   logic [4:0]           r_exccode;
   // Other registers
   logic [31:0]          r_epc;
   logic [31:0]          r_badvaddr;

   logic [31:0]          w_count;
   logic [31:0]          w_compare;
   logic                 w_ti;
   logic [NUM_HWINT-1:0] w_line;
   logic                 w_req_int;
   logic                 w_req_ex;
   logic                 w_wr_ok;
   logic [31:0]          w_exc_pc;
   logic [31:0]          w_sr;
   logic [31:0]          w_cause;

   // mtc0 writes are dropped in any cycle that takes an exception or interrupt.
   assign w_wr_ok = we && !req;

   cp0_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_we      (w_wr_ok),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .o_count   (w_count),
      .o_compare (w_compare),
      .o_ti      (w_ti)
   );

   // Interrupt lines: external levels with the timer ORed onto its line.
   always_comb begin
      w_line             = hwint;
      w_line[TIMER_LINE] = hwint[TIMER_LINE] | w_ti;
   end

   assign w_req_int = (|(w_line & r_im)) && r_ie && !r_exl;
   assign w_req_ex  = (excode != EXC_INT) && !r_exl;
   assign req       = w_req_int || w_req_ex;
   assign w_exc_pc  = bd_in ? (pc - 32'd4) : pc;
   assign epc_out   = req ? w_exc_pc : r_epc;
   assign timer_irq = w_ti;

   // SR: exception entry sets EXL, eret clears it, otherwise mtc0 loads the writable fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_im  <= '0;
         r_exl <= 1'b0;
         r_ie  <= 1'b0;
      end else begin
         if (w_wr_ok && (waddr == REG_SR)) begin
            r_im <= wdata[SR_IM_LSB +: NUM_HWINT];
            r_ie <= wdata[SR_IE];
         end
         if (req) begin
            r_exl <= 1'b1;
         end else if (eret) begin
            r_exl <= 1'b0;
         end else if (w_wr_ok && (waddr == REG_SR)) begin
            r_exl <= wdata[SR_EXL];
         end
      end
   end

   // Cause/BadVAddr: IP samples the lines every cycle; BD, ExcCode and BadVAddr update on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bd       <= 1'b0;
         r_ip       <= '0;
         r_exccode  <= '0;
         r_badvaddr <= '0;
      end else begin
         r_ip <= w_line;
         if (req) begin
            r_bd      <= bd_in;
            r_exccode <= w_req_int ? EXC_INT : excode;
            if (!w_req_int && is_addr_exc(excode)) begin
               r_badvaddr <= badvaddr_in;
            end
         end
      end
   end

   // EPC: captures the restart PC on entry, otherwise writable by mtc0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_epc <= '0;
      end else if (req) begin
         r_epc <= w_exc_pc;
      end else if (w_wr_ok && (waddr == REG_EPC)) begin
         r_epc <= wdata;
      end
   end

   // Assemble the SR and Cause read images from their fields.
   always_comb begin
      w_sr                                   = '0;
      w_sr[SR_IM_LSB +: NUM_HWINT]           = r_im;
      w_sr[SR_EXL]                           = r_exl;
      w_sr[SR_IE]                            = r_ie;
      w_cause                                = '0;
      w_cause[CAUSE_BD]                      = r_bd;
      w_cause[CAUSE_TI]                      = w_ti;
      w_cause[CAUSE_IP_LSB +: NUM_HWINT]     = r_ip;
      w_cause[CAUSE_EXC_LSB +: 5]            = r_exccode;
   end

   // mfc0 read mux; EPC reads through the bypass so it shows the entry PC during req.
   always_comb begin
      rdata = '0;
      case (raddr)
         REG_BADVADDR: rdata = r_badvaddr;
         REG_COUNT:    rdata = w_count;
         REG_COMPARE:  rdata = w_compare;
         REG_SR:       rdata = w_sr;
         REG_CAUSE:    rdata = w_cause;
         REG_EPC:      rdata = epc_out;
         REG_PRID:     rdata = PRID_VAL;
         default:      rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Bench for cp0_timer_ctrl: directed scenarios followed by random traffic, all
// checked against an architectural model of CP0 through an expected-output queue.
module tb_cp0_timer_ctrl;

   localparam logic [31:0] PRID = 32'h2001_1123;

   // clock / reset and DUT signals
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  raddr;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] pc;
   logic [4:0]  excode;
   logic        bd_in;
   logic [31:0] badvaddr_in;
   logic [5:0]  hwint;
   logic        eret;
   logic        req;
   logic [31:0] epc_out;
   logic [31:0] rdata;
   logic        timer_irq;

   always #5 clk = ~clk;

   cp0_timer_ctrl #(
      .NUM_HWINT  (6),
      .TIMER_LINE (5),
      .PRID_VAL   (PRID)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .raddr       (raddr),
      .waddr       (waddr),
      .wdata       (wdata),
      .we          (we),
      .pc          (pc),
      .excode      (excode),
      .bd_in       (bd_in),
      .badvaddr_in (badvaddr_in),
      .hwint       (hwint),
      .eret        (eret),
      .req         (req),
      .epc_out     (epc_out),
      .rdata       (rdata),
      .timer_irq   (timer_irq)
   );

   // architectural model state
   logic [5:0]  m_im;
   logic        m_exl;
   logic        m_ie;
   logic        m_bd;
   logic        m_ti;
   logic [4:0]  m_exc;
   logic [5:0]  m_ip;
   logic [31:0] m_epc;
   logic [31:0] m_bva;
   logic [31:0] m_count;
   logic [31:0] m_cmp;

   // scoreboard: {req, timer_irq, epc_out, rdata}
   logic [65:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [5:0] m_line();
      return hwint | (m_ti ? 6'b10_0000 : 6'b00_0000);
   endfunction

   function automatic logic m_req_int();
      return ((m_line() & m_im) != 6'd0) && m_ie && !m_exl;
   endfunction

   function automatic logic m_req();
      return m_req_int() || ((excode != 5'd0) && !m_exl);
   endfunction

   function automatic logic [31:0] m_epc_out();
      if (m_req()) return bd_in ? (pc - 32'd4) : pc;
      return m_epc;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_bva;
         5'd9:    return m_count;
         5'd11:   return m_cmp;
         5'd12:   return {16'd0, m_im, 8'd0, m_exl, m_ie};
         5'd13:   return {m_bd, m_ti, 14'd0, m_ip, 3'd0, m_exc, 2'd0};
         5'd14:   return m_epc_out();
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model across one clock edge using the inputs of the ending cycle.
   task automatic model_edge();
      logic        r_int;
      logic        r_any;
      logic        wr_ok;
      logic [31:0] e_pc;
      logic [5:0]  ln;
      if (reset) begin
         m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_exc = 0;
         m_ip = 0; m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0;
         return;
      end
      r_int = m_req_int();
      r_any = m_req();
      e_pc  = m_epc_out();
      ln    = m_line();
      wr_ok = we && !r_any;
      if (wr_ok && waddr == 5'd11) m_ti = 1'b0;
      else if (m_count == m_cmp)  m_ti = 1'b1;
      if (wr_ok && waddr == 5'd11) m_cmp = wdata;
      m_count = (wr_ok && waddr == 5'd9) ? wdata : m_count + 32'd1;
      m_ip = ln;
      if (r_any) begin
         m_exl = 1'b1;
         m_bd  = bd_in;
         m_epc = e_pc;
         m_exc = r_int ? 5'd0 : excode;
         if (!r_int && (excode == 5'd4 || excode == 5'd5)) m_bva = badvaddr_in;
      end else begin
         if (wr_ok && waddr == 5'd12) begin
            m_im  = wdata[15:10];
            m_exl = wdata[1];
            m_ie  = wdata[0];
         end
         if (wr_ok && waddr == 5'd14) m_epc = wdata;
         if (eret) m_exl = 1'b0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // monitor: pops one expected packet per driven cycle and compares the settled outputs
   initial begin
      logic [65:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("req",       {31'd0, req},       {31'd0, e[65]});
            check("timer_irq", {31'd0, timer_irq}, {31'd0, e[64]});
            check("epc_out",   epc_out,            e[63:32]);
            check("rdata",     rdata,              e[31:0]);
         end
      end
   end

   // driver tasks
   task automatic begin_cycle();
      @(negedge clk);
      reset = 0; we = 0; waddr = 0; wdata = 0; raddr = 0; pc = 0;
      excode = 0; bd_in = 0; badvaddr_in = 0; hwint = 0; eret = 0;
   endtask

   task automatic settle();
      #1;
      exp_q.push_back({m_req(), m_ti, m_epc_out(), m_read(raddr)});
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_edge();
   endtask

   task automatic reset_cycle();
      begin_cycle();
      reset = 1;
      finish_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         begin_cycle(); settle(); finish_cycle();
      end
   endtask

   logic [4:0] addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
   logic [4:0] codes [7] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};

   initial begin
      reset = 1; we = 0; waddr = 0; wdata = 0; raddr = 0; pc = 0;
      excode = 0; bd_in = 0; badvaddr_in = 0; hwint = 0; eret = 0;
      @(posedge clk); model_edge();
      reset_cycle();

      // timer: Compare=10 on the first cycle after reset, then SR=0x8401
      begin_cycle(); we = 1; waddr = 5'd11; wdata = 32'd10; settle();
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_tirq", {31'd0, timer_irq}, 32'd0);
      check("rst_epc", epc_out, 32'd0);
      finish_cycle();
      begin_cycle(); we = 1; waddr = 5'd12; wdata = 32'h0000_8401; settle(); finish_cycle();
      idle(8);
      begin_cycle(); settle();
      check("tirq_early", {31'd0, timer_irq}, 32'd0);
      finish_cycle();
      begin_cycle(); settle();
      check("tirq_rise", {31'd0, timer_irq}, 32'd1);
      check("tirq_req", {31'd0, req}, 32'd1);
      finish_cycle();
      begin_cycle(); we = 1; waddr = 5'd11; wdata = 32'hFFFF_0000; settle();
      check("exl_blocks", {31'd0, req}, 32'd0);
      finish_cycle();
      begin_cycle(); settle();
      check("tirq_clear", {31'd0, timer_irq}, 32'd0);
      finish_cycle();
      begin_cycle(); eret = 1; settle(); finish_cycle();

      // hardware interrupt on line 5
      begin_cycle(); hwint = 6'b10_0000; settle();
      check("hw_req", {31'd0, req}, 32'd1);
      finish_cycle();
      begin_cycle(); hwint = 6'b10_0000; raddr = 5'd13; settle();
      check("hw_req_exl", {31'd0, req}, 32'd0);
      check("hw_exccode", {27'd0, rdata[6:2]}, 32'd0);
      finish_cycle();
      begin_cycle(); raddr = 5'd12; settle();
      check("hw_sr", rdata, 32'h0000_8403);
      finish_cycle();
      begin_cycle(); eret = 1; settle(); finish_cycle();

      // address error in a delay slot
      begin_cycle(); excode = 5'd4; pc = 32'h3004; bd_in = 1; badvaddr_in = 32'h1001; settle();
      check("ade_epc", epc_out, 32'h3000);
      finish_cycle();
      begin_cycle(); raddr = 5'd13; settle();
      check("ade_cause", rdata, 32'h8000_0010);
      finish_cycle();
      begin_cycle(); raddr = 5'd8; settle();
      check("ade_bva", rdata, 32'h1001);
      finish_cycle();
      begin_cycle(); eret = 1; settle(); finish_cycle();

      // mtc0 EPC suppressed by overflow exception
      begin_cycle(); we = 1; waddr = 5'd14; wdata = 32'h5000; excode = 5'd12; pc = 32'h3008; settle();
      finish_cycle();
      begin_cycle(); raddr = 5'd14; settle();
      check("ov_epc", rdata, 32'h3008);
      finish_cycle();
      begin_cycle(); eret = 1; settle(); finish_cycle();

      // eret colliding with an exception, then a lone eret
      begin_cycle(); eret = 1; excode = 5'd10; pc = 32'h4000; settle(); finish_cycle();
      begin_cycle(); raddr = 5'd12; settle();
      check("eret_ex_sr", rdata, 32'h0000_8403);
      finish_cycle();
      begin_cycle(); eret = 1; settle(); finish_cycle();
      begin_cycle(); raddr = 5'd12; settle();
      check("eret_sr", rdata, 32'h0000_8401);
      finish_cycle();

      // reset while EXL=1 and TI=1
      begin_cycle(); excode = 5'd10; pc = 32'h4100; settle(); finish_cycle();
      begin_cycle(); we = 1; waddr = 5'd11; wdata = m_count + 32'd3; settle(); finish_cycle();
      idle(3);
      begin_cycle(); raddr = 5'd12; settle();
      check("pre_rst_ti", {31'd0, timer_irq}, 32'd1);
      check("pre_rst_sr", rdata, 32'h0000_8403);
      finish_cycle();
      reset_cycle();
      begin_cycle(); raddr = 5'd13; settle();
      check("post_rst_cause", rdata, 32'd0);
      check("post_rst_epc", epc_out, 32'd0);
      finish_cycle();
      begin_cycle(); raddr = 5'd9; settle();
      check("post_rst_count", rdata, 32'd1);
      finish_cycle();
      begin_cycle(); raddr = 5'd12; settle();
      check("post_rst_sr", rdata, 32'd0);
      finish_cycle();

      // random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         begin_cycle();
         if ($urandom_range(0, 199) == 0) begin
            reset = 1;
            finish_cycle();
            continue;
         end
         hwint       = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         excode      = codes[$urandom_range(0, 6)];
         eret        = ($urandom_range(0, 5) == 0);
         we          = ($urandom_range(0, 2) == 0);
         waddr       = addrs[$urandom_range(0, 7)];
         wdata       = $urandom;
         if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(0, 6));
         raddr       = addrs[$urandom_range(0, 7)];
         pc          = $urandom & 32'hFFFF_FFFC;
         bd_in       = ($urandom_range(0, 1) == 1);
         badvaddr_in = $urandom;
         settle();
         finish_cycle();
      end

      @(negedge clk);
      #3;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
